mpu_ebi_slave: RTL and testbench

- Bridges the external microcontroller's asynchronous parallel EBI read/write bus to the tag data buffer's read port in the FPGA clock domain.
- Synchronises the bus strobes and decodes a 4-register address map (status, data pop, pop count, control).
- Issues exactly one rd_ena pulse per data-register read and captures the buffer's rd_data for the MCU.
- Sits directly downstream of the tag data buffer (consumes rd_ready/rd_data, drives rd_ena).

---
 rtl/mpu_ebi_slave.sv | 205 ++++++++++++++++++++
 tb/tb_mpu_ebi_slave.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_ebi_slave.sv
// mpu_ebi_slave
// Bridges the MCU's asynchronous EBI bus into the core clock domain and serves
// a four-register map: STATUS, DATA (pops the tag buffer), COUNT and CTRL.
// Each bus strobe is handled exactly once. The FSM parks in HOLD until both
// strobes are released, so a long strobe can never cause a second pop.

module mpu_ebi_slave #(
    parameter int READ_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int READ_LATENCY = 1,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ebi_cs_n,
    input  logic                  ebi_rd_n,
    input  logic                  ebi_wr_n,
    input  logic [ADDR_WIDTH-1:0] ebi_addr,
    input  logic [READ_WIDTH-1:0] ebi_din,
    output logic [READ_WIDTH-1:0] ebi_dout,
    output logic                  ebi_doe,
    output logic                  rd_ena,
    input  logic                  rd_ready,
    input  logic [READ_WIDTH-1:0] rd_data,
    output logic                  irq
);

    // Synchroniser word: {cs_n, rd_n, wr_n, addr, din}. Strobes reset inactive (high).
    localparam int SYNC_W = 3 + ADDR_WIDTH + READ_WIDTH;
    localparam logic [SYNC_W-1:0] SYNC_RST = {3'b111, {(ADDR_WIDTH + READ_WIDTH){1'b0}}};

    // Latency down-counter: loaded on leaving POP, rd_data sampled when it expires.
    localparam int WAIT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(READ_LATENCY);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_POP  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    logic [SYNC_STAGES-1:0][SYNC_W-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0]             sync_vld_q, sync_vld_d;

    logic                  cs_s, rd_s, wr_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [READ_WIDTH-1:0] din_s;
    logic                  rd_act, wr_act;
    logic [1:0]            reg_sel;
    logic [READ_WIDTH-1:0] reg_word;

    logic [1:0]             state_q, state_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [READ_WIDTH-1:0]  dout_q, dout_d;
    logic                   doe_q, doe_d;
    logic                   rd_ena_q, rd_ena_d;
    logic                   rd_acc_q, rd_acc_d;
    logic                   armed_q, armed_d;
    logic                   irq_en_q, irq_en_d;
    logic                   underflow_q, underflow_d;
    logic [COUNT_WIDTH-1:0] pop_cnt_q, pop_cnt_d;
    logic                   unused_din;

    assign {cs_s, rd_s, wr_s, addr_s, din_s} = sync_q[SYNC_STAGES-1];
    assign rd_act  = ~cs_s & ~rd_s;
    assign wr_act  = ~cs_s & ~wr_s;
    assign reg_sel = addr_s[1:0];

    // Only CTRL bits 1:0 are writable.
    assign unused_din = ^din_s[READ_WIDTH-1:2];

    assign ebi_dout = dout_q;
    assign ebi_doe  = doe_q;
    assign rd_ena   = rd_ena_q;
    assign irq      = rd_ready & irq_en_q;

    // Shift the async bus through the synchroniser chain. sync_vld marks when
    // the last stage holds a real bus sample rather than its reset value.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = {ebi_cs_n, ebi_rd_n, ebi_wr_n, ebi_addr, ebi_din};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        sync_vld_d = {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
    end

    // Read mux for the non-popping registers; CTRL is write-only and reads zero.
    always_comb begin
        reg_word = '0;
        case (reg_sel)
            REG_STATUS: reg_word[2:0] = {irq_en_q, underflow_q, rd_ready};
            REG_COUNT:  reg_word      = READ_WIDTH'(pop_cnt_q);
            default:    reg_word      = '0;
        endcase
    end

    // Access FSM: decode in IDLE, pop and wait for buffer data, then hold until release.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        dout_d      = dout_q;
        rd_acc_d    = rd_acc_q;
        armed_d     = armed_q;
        irq_en_d    = irq_en_q;
        underflow_d = underflow_q;
        pop_cnt_d   = pop_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // After reset, a strobe that is still low must be released
                // before it can start an access.
                if (sync_vld_q[SYNC_STAGES-1] && !rd_act && !wr_act) begin
                    armed_d = 1'b1;
                end
                if (armed_q && rd_act) begin
                    // A read wins over a simultaneous write, which is dropped.
                    rd_acc_d = 1'b1;
                    if (reg_sel == REG_DATA) begin
                        if (rd_ready) begin
                            state_d = ST_POP;
                        end else begin
                            underflow_d = 1'b1;
                            dout_d      = '0;
                            state_d     = ST_HOLD;
                        end
                    end else begin
                        dout_d  = reg_word;
                        state_d = ST_HOLD;
                    end
                end else if (armed_q && wr_act) begin
                    rd_acc_d = 1'b0;
                    if (reg_sel == REG_CTRL) begin
                        irq_en_d = din_s[0];
                        if (din_s[1]) begin
                            pop_cnt_d   = '0;
                            underflow_d = 1'b0;
                        end
                    end
                    state_d = ST_HOLD;
                end
            end
            ST_POP: begin
                wait_d  = WAIT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q <= WAIT_W'(1)) begin
                    dout_d    = rd_data;
                    pop_cnt_d = pop_cnt_q + 1'b1;
                    wait_d    = '0;
                    state_d   = ST_HOLD;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (!rd_act && !wr_act) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rd_ena_d = (state_d == ST_POP);
        doe_d    = (state_d == ST_HOLD) && rd_acc_d && rd_act;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= {SYNC_STAGES{SYNC_RST}};
            sync_vld_q  <= '0;
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            dout_q      <= '0;
            doe_q       <= 1'b0;
            rd_ena_q    <= 1'b0;
            rd_acc_q    <= 1'b0;
            armed_q     <= 1'b0;
            irq_en_q    <= 1'b0;
            underflow_q <= 1'b0;
            pop_cnt_q   <= '0;
        end else begin
            sync_q      <= sync_d;
            sync_vld_q  <= sync_vld_d;
            state_q     <= state_d;
            wait_q      <= wait_d;
            dout_q      <= dout_d;
            doe_q       <= doe_d;
            rd_ena_q    <= rd_ena_d;
            rd_acc_q    <= rd_acc_d;
            armed_q     <= armed_d;
            irq_en_q    <= irq_en_d;
            underflow_q <= underflow_d;
            pop_cnt_q   <= pop_cnt_d;
        end
    end

endmodule

// File: tb/tb_mpu_ebi_slave.sv
// Bench for mpu_ebi_slave: a register-access vector table plus hand-written
// sequences for long strobes, counter wrap (narrow-counter instance) and reset
// during a pop.

module tb_mpu_ebi_slave;

    localparam int RW      = 16;
    localparam int SYNC    = 2;
    localparam int SETTLE  = 6;
    localparam int NV      = 22;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          cs_n, cs2_n, rd_n, wr_n;
    logic [1:0]    addr;
    logic [RW-1:0] din;
    logic [RW-1:0] dout, dout2;
    logic          doe, doe2, rd_ena, rd_ena2, rd_ready, irq, irq2;
    logic [RW-1:0] rd_data = '0;

    mpu_ebi_slave #(.READ_WIDTH(RW), .ADDR_WIDTH(2), .SYNC_STAGES(SYNC),
                    .READ_LATENCY(1), .COUNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .ebi_cs_n(cs_n), .ebi_rd_n(rd_n), .ebi_wr_n(wr_n),
        .ebi_addr(addr), .ebi_din(din), .ebi_dout(dout), .ebi_doe(doe),
        .rd_ena(rd_ena), .rd_ready(rd_ready), .rd_data(rd_data), .irq(irq)
    );

    // Narrow pop counter so the wrap can be reached in a few accesses.
    mpu_ebi_slave #(.READ_WIDTH(RW), .ADDR_WIDTH(2), .SYNC_STAGES(SYNC),
                    .READ_LATENCY(1), .COUNT_WIDTH(4)) dut2 (
        .clk(clk), .rst(rst), .ebi_cs_n(cs2_n), .ebi_rd_n(rd_n), .ebi_wr_n(wr_n),
        .ebi_addr(addr), .ebi_din(din), .ebi_dout(dout2), .ebi_doe(doe2),
        .rd_ena(rd_ena2), .rd_ready(1'b1), .rd_data(16'h00C3), .irq(irq2)
    );

    // Tag buffer model: pops on rd_ena, data valid one cycle later.
    logic [RW-1:0] mem [0:15];
    int head = 0;
    int tail = 0;
    assign rd_ready = (head != tail);
    always @(posedge clk) begin
        if (rd_ena) begin
            rd_data <= mem[head % 16];
            head    <= head + 1;
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    int pulses = 0, pulses2 = 0, viol = 0, irq_err = 0;
    logic prev_ena = 1'b0;
    logic irq_mon = 1'b0;
    logic exp_irq_en = 1'b0;

    always @(posedge clk) begin
        if (rd_ena) pulses++;
        if (rd_ena2) pulses2++;
        if (rd_ena && (prev_ena || !rd_ready)) viol++;
        prev_ena = rd_ena;
    end

    always @(negedge clk) begin
        if (irq_mon && (irq !== (rd_ready & exp_irq_en))) irq_err++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [RW-1:0] v);
        mem[tail % 16] = v;
        tail = tail + 1;
    endtask

    // One bus access. kind: 0 read, 1 write, 2 read+write strobes together.
    task automatic bus_op(input int sel, input int kind, input logic [1:0] a,
                          input logic [RW-1:0] d, input int hold,
                          output logic [RW-1:0] rdout, output int npulse,
                          output int doe_low, output int rel);
        int p0;
        @(negedge clk);
        p0   = (sel == 0) ? pulses : pulses2;
        addr = a;
        din  = d;
        if (sel == 0) cs_n = 1'b0; else cs2_n = 1'b0;
        if (kind != 1) rd_n = 1'b0;
        if (kind != 0) wr_n = 1'b0;
        doe_low = 0;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (i >= SETTLE && kind != 1 && !((sel == 0) ? doe : doe2)) doe_low++;
        end
        rdout = (sel == 0) ? dout : dout2;
        cs_n = 1'b1; cs2_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        rel = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (rel == 0 && !((sel == 0) ? doe : doe2)) rel = i;
        end
        npulse = ((sel == 0) ? pulses : pulses2) - p0;
    endtask

    typedef struct {
        int          sel;
        int          kind;
        logic [1:0]  a;
        logic [15:0] d;
        int          push;
        logic [15:0] pval;
        int          chk;
        logic [15:0] exp;
        int          npulse;
        int          irq_x;
    } vec_t;

    vec_t tbl [NV];

    logic [RW-1:0] rdv;
    int np, dl, rel, tot, found, p0, doe_hi;

    initial begin
        //         sel kind addr  wdata    push pval      chk exp       pul irq
        tbl[0]  = '{0, 0, 2'd0, 16'h0000, 1, 16'h1234, 1, 16'h0001, 0, -1};
        tbl[1]  = '{0, 0, 2'd1, 16'h0000, 1, 16'hABCD, 1, 16'h1234, 1, -1};
        tbl[2]  = '{0, 0, 2'd1, 16'h0000, 0, 16'h0000, 1, 16'hABCD, 1, -1};
        tbl[3]  = '{0, 0, 2'd2, 16'h0000, 0, 16'h0000, 1, 16'h0002, 0, -1};
        tbl[4]  = '{0, 0, 2'd1, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, -1};
        tbl[5]  = '{0, 0, 2'd0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 0, -1};
        tbl[6]  = '{0, 0, 2'd2, 16'h0000, 0, 16'h0000, 1, 16'h0002, 0, -1};
        tbl[7]  = '{0, 2, 2'd3, 16'h0002, 0, 16'h0000, 1, 16'h0000, 0, -1};
        tbl[8]  = '{0, 0, 2'd0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 0, -1};
        tbl[9]  = '{0, 1, 2'd3, 16'h0002, 0, 16'h0000, 0, 16'h0000, 0, -1};
        tbl[10] = '{0, 0, 2'd0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, -1};
        tbl[11] = '{0, 0, 2'd2, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, -1};
        tbl[12] = '{0, 1, 2'd2, 16'hFFFF, 0, 16'h0000, 0, 16'h0000, 0, -1};
        tbl[13] = '{0, 0, 2'd2, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, -1};
        tbl[14] = '{0, 0, 2'd0, 16'h0000, 1, 16'h5A5A, 1, 16'h0001, 0,  0};
        tbl[15] = '{0, 1, 2'd3, 16'h0001, 0, 16'h0000, 0, 16'h0000, 0,  1};
        tbl[16] = '{0, 0, 2'd0, 16'h0000, 0, 16'h0000, 1, 16'h0005, 0,  1};
        tbl[17] = '{0, 0, 2'd1, 16'h0000, 0, 16'h0000, 1, 16'h5A5A, 1,  0};
        tbl[18] = '{0, 0, 2'd0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 0,  0};
        tbl[19] = '{0, 1, 2'd3, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, -1};
        tbl[20] = '{0, 0, 2'd0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, -1};
        tbl[21] = '{0, 0, 2'd3, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, -1};

        rst = 1'b1; cs_n = 1'b1; cs2_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        addr = '0; din = '0;
        repeat (3) @(negedge clk);
        check("reset_dout", dout, 16'h0000);
        check("reset_doe", doe, 1'b0);
        check("reset_rd_ena", rd_ena, 1'b0);
        check("reset_irq", irq, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        irq_mon = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if (tbl[i].push != 0) push(tbl[i].pval);
            if (tbl[i].kind != 0 && tbl[i].a == 2'd3) irq_mon = 1'b0;
            bus_op(tbl[i].sel, tbl[i].kind, tbl[i].a, tbl[i].d, 10, rdv, np, dl, rel);
            if (tbl[i].kind == 1 && tbl[i].a == 2'd3) exp_irq_en = tbl[i].d[0];
            irq_mon = 1'b1;
            if (tbl[i].chk != 0) check($sformatf("vec%0d_dout", i), rdv, tbl[i].exp);
            check($sformatf("vec%0d_pulses", i), np, tbl[i].npulse);
            if (tbl[i].kind != 1) check($sformatf("vec%0d_doe_hold", i), dl, 0);
            if (tbl[i].irq_x >= 0) check($sformatf("vec%0d_irq", i), irq, tbl[i].irq_x[0]);
        end

        // Long strobe on DATA: one pop, doe held, doe drops soon after release.
        push(16'hBEEF);
        bus_op(0, 0, 2'd1, 16'h0000, 200, rdv, np, dl, rel);
        check("long_dout", rdv, 16'hBEEF);
        check("long_pulses", np, 1);
        check("long_doe_hold", dl, 0);
        check("long_doe_release", (rel >= 1 && rel <= SYNC + 1), 1);

        // Pop counter wrap on the 4-bit instance.
        tot = 0;
        for (int i = 0; i < 15; i++) begin
            bus_op(1, 0, 2'd1, 16'h0000, 8, rdv, np, dl, rel);
            tot += np;
        end
        check("wrap_pulses", tot, 15);
        bus_op(1, 0, 2'd2, 16'h0000, 8, rdv, np, dl, rel);
        check("wrap_count_max", rdv, 16'h000F);
        bus_op(1, 0, 2'd1, 16'h0000, 8, rdv, np, dl, rel);
        check("wrap_pop_data", rdv, 16'h00C3);
        check("wrap_pop_pulse", np, 1);
        bus_op(1, 0, 2'd2, 16'h0000, 8, rdv, np, dl, rel);
        check("wrap_count_zero", rdv, 16'h0000);

        // Reset while waiting for pop data, with the strobe still low.
        push(16'h1111);
        push(16'h2222);
        @(negedge clk);
        addr = 2'd1; cs_n = 1'b0; rd_n = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (rd_ena) found = 1;
        end
        check("rst_pop_seen", found, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_rd_ena", rd_ena, 1'b0);
        check("rst_doe", doe, 1'b0);
        rst = 1'b0;
        p0 = pulses;
        doe_hi = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (doe) doe_hi++;
        end
        check("rst_no_repop", pulses - p0, 0);
        check("rst_no_doe", doe_hi, 0);
        cs_n = 1'b1; rd_n = 1'b1;
        repeat (8) @(negedge clk);
        bus_op(0, 0, 2'd2, 16'h0000, 10, rdv, np, dl, rel);
        check("rst_count_cleared", rdv, 16'h0000);
        bus_op(0, 0, 2'd1, 16'h0000, 10, rdv, np, dl, rel);
        check("rst_reaccess_data", rdv, 16'h2222);
        check("rst_reaccess_pulse", np, 1);
        bus_op(0, 0, 2'd2, 16'h0000, 10, rdv, np, dl, rel);
        check("rst_count_after", rdv, 16'h0001);

        check("rd_ena_rules", viol, 0);
        check("irq_tracking", irq_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
